intrusion_detection_qpn_filter: RTL and testbench

INTRUSION_DETECTION_QPN_FILTER -- requirements
Module: intrusion_detection_qpn_filter

---
 rtl/intrusion_detection_pkg.sv | 35 +++
 rtl/intrusion_detection_qpn_blocklist.sv | 94 +++++++++
 rtl/intrusion_detection_qpn_filter.sv | 126 ++++++++++++
 tb/tb_intrusion_detection_qpn_filter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intrusion_detection_pkg.sv
// Shared types and RoCE header constants for the intrusion detection path
// (QPN filter and data aggregator).
package intrusion_detection_pkg;

  localparam int unsigned QPN_W  = 24;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned OPC_W  = 8;

  typedef logic [QPN_W-1:0]  qpn_t;
  typedef logic [DATA_W-1:0] data_word_t;
  typedef logic [KEEP_W-1:0] data_keep_t;
  typedef logic [OPC_W-1:0]  opcode_t;

  typedef struct packed {
    data_word_t tdata;
    data_keep_t tkeep;
    logic       tlast;
  } axis_beat_t;

  // Header field positions inside the first beat of a packet
  localparam int unsigned OPC_LSB = 224;
  localparam int unsigned QPN_LSB = 264;

  localparam opcode_t OPC_WRITE_FIRST  = 8'h06;
  localparam opcode_t OPC_WRITE_MIDDLE = 8'h07;
  localparam opcode_t OPC_WRITE_LAST   = 8'h08;
  localparam opcode_t OPC_WRITE_ONLY   = 8'h0A;

  function automatic logic is_write_opcode(input opcode_t op);
    return (op == OPC_WRITE_FIRST) || (op == OPC_WRITE_MIDDLE) ||
           (op == OPC_WRITE_LAST)  || (op == OPC_WRITE_ONLY);
  endfunction

endpackage

// File: rtl/intrusion_detection_qpn_blocklist.sv
// Fully associative table of blocked QPNs with round-robin replacement when full;
// lookup is combinational against the current (pre-update) table.
module intrusion_detection_qpn_blocklist
  import intrusion_detection_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        verdict_ok_i,
  input  logic [QPN_W-1:0]            verdict_qpn_i,
  input  logic [QPN_W-1:0]            lookup_qpn_i,
  output logic                        lookup_hit_c,
  output logic [$clog2(N_ENTRIES):0]  occupancy_o
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);
  localparam int unsigned OCC_W = IDX_W + 1;

  logic [N_ENTRIES-1:0] valid_q, valid_d;
  qpn_t                 qpn_q [N_ENTRIES];
  qpn_t                 qpn_d [N_ENTRIES];
  logic [IDX_W-1:0]     victim_q, victim_d;
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic [N_ENTRIES-1:0] verdict_match;
  logic [N_ENTRIES-1:0] lookup_match;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  // Parallel compare for both the verdict QPN and the header lookup QPN
  always_comb begin
    verdict_match = '0;
    lookup_match  = '0;
    free_found    = 1'b0;
    free_idx      = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      verdict_match[i] = valid_q[i] && (qpn_q[i] == verdict_qpn_i);
      lookup_match[i]  = valid_q[i] && (qpn_q[i] == lookup_qpn_i);
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    lookup_hit_c = |lookup_match;
  end

  always_comb begin
    valid_d  = valid_q;
    qpn_d    = qpn_q;
    victim_d = victim_q;
    occ_d    = '0;
    if (flush_i) begin
      valid_d  = '0;
      victim_d = '0;
    end else if (verdict_qpn_i != '0) begin
      if (!verdict_ok_i && (verdict_match == '0)) begin
        if (free_found) begin
          valid_d[free_idx] = 1'b1;
          qpn_d[free_idx]   = verdict_qpn_i;
        end else begin
          qpn_d[victim_q] = verdict_qpn_i;
          victim_d        = victim_q + IDX_W'(1);
        end
      end else if (verdict_ok_i) begin
        valid_d = valid_q & ~verdict_match;
      end
    end
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      victim_q <= '0;
      occ_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      victim_q <= victim_d;
      occ_q    <= occ_d;
    end
  end

  // QPN payload needs no reset: entries are qualified by valid_q
  always_ff @(posedge clk) begin
    qpn_q <= qpn_d;
  end

  assign occupancy_o = occ_q;

endmodule

// File: rtl/intrusion_detection_qpn_filter.sv
// Drops RDMA WRITE packets whose destination QPN is on the blocklist; all other
// traffic passes through a single output register stage.
module intrusion_detection_qpn_filter
  import intrusion_detection_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                        nclk,
  input  logic                        nresetn,
  input  logic [DATA_W-1:0]           s_axis_rx_tdata,
  input  logic [KEEP_W-1:0]           s_axis_rx_tkeep,
  input  logic                        s_axis_rx_tlast,
  input  logic                        s_axis_rx_tvalid,
  output logic                        s_axis_rx_tready,
  output logic [DATA_W-1:0]           m_axis_rx_tdata,
  output logic [KEEP_W-1:0]           m_axis_rx_tkeep,
  output logic                        m_axis_rx_tlast,
  output logic                        m_axis_rx_tvalid,
  input  logic                        m_axis_rx_tready,
  input  logic                        acceptable_traffic_i,
  input  logic [QPN_W-1:0]            qpn_traffic_i,
  input  logic                        flush_i,
  output logic [CNT_BITS-1:0]         drop_count_o,
  output logic [$clog2(N_ENTRIES):0]  blocked_entries_o
);

  localparam logic [1:0] ST_HEADER = 2'd0;
  localparam logic [1:0] ST_FWD    = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  logic [1:0]          state_q, state_d;
  axis_beat_t          out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  logic    accept_c;
  logic    hit_c;
  logic    hdr_drop_c;
  logic    fwd;
  opcode_t hdr_opcode_c;
  qpn_t    hdr_qpn_c;

  assign s_axis_rx_tready = nresetn && (!out_valid_q || m_axis_rx_tready);
  assign accept_c         = s_axis_rx_tvalid && s_axis_rx_tready;
  assign hdr_opcode_c     = s_axis_rx_tdata[OPC_LSB +: OPC_W];
  assign hdr_qpn_c        = s_axis_rx_tdata[QPN_LSB +: QPN_W];
  assign hdr_drop_c       = is_write_opcode(hdr_opcode_c) && hit_c;

  intrusion_detection_qpn_blocklist #(
    .N_ENTRIES (N_ENTRIES)
  ) u_blocklist (
    .clk           (nclk),
    .rst_n         (nresetn),
    .flush_i       (flush_i),
    .verdict_ok_i  (acceptable_traffic_i),
    .verdict_qpn_i (qpn_traffic_i),
    .lookup_qpn_i  (hdr_qpn_c),
    .lookup_hit_c  (hit_c),
    .occupancy_o   (blocked_entries_o)
  );

  // Per-packet verdict is taken on the header beat and held until tlast
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    drop_cnt_d  = drop_cnt_q;
    fwd         = 1'b0;
    if (out_valid_q && m_axis_rx_tready) begin
      out_valid_d = 1'b0;
    end
    if (accept_c) begin
      case (state_q)
        ST_HEADER: begin
          if (hdr_drop_c) begin
            if (drop_cnt_q != '1) begin
              drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
            end
            state_d = s_axis_rx_tlast ? ST_HEADER : ST_DROP;
          end else begin
            fwd     = 1'b1;
            state_d = s_axis_rx_tlast ? ST_HEADER : ST_FWD;
          end
        end
        ST_FWD: begin
          fwd = 1'b1;
          if (s_axis_rx_tlast) state_d = ST_HEADER;
        end
        ST_DROP: begin
          if (s_axis_rx_tlast) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
    if (fwd) begin
      out_d.tdata = s_axis_rx_tdata;
      out_d.tkeep = s_axis_rx_tkeep;
      out_d.tlast = s_axis_rx_tlast;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge nclk) begin
    if (!nresetn) begin
      state_q     <= ST_HEADER;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge nclk) begin
    out_q <= out_d;
  end

  assign m_axis_rx_tdata  = out_q.tdata;
  assign m_axis_rx_tkeep  = out_q.tkeep;
  assign m_axis_rx_tlast  = out_q.tlast;
  assign m_axis_rx_tvalid = out_valid_q;
  assign drop_count_o     = drop_cnt_q;

endmodule

// File: tb/tb_intrusion_detection_qpn_filter.sv
// Randomized and directed checks of the QPN filter against a packet-level model.
module tb_intrusion_detection_qpn_filter;
  import intrusion_detection_pkg::*;

  localparam int unsigned N = 16;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic         nclk = 1'b0;
  logic         nresetn = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [63:0]  s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         acceptable_traffic_i = 1'b1;
  logic [23:0]  qpn_traffic_i = '0;
  logic         flush_i = 1'b0;
  logic [31:0]  drop_count_o;
  logic [4:0]   blocked_entries_o;

  always #5 nclk = ~nclk;

  intrusion_detection_qpn_filter #(
    .N_ENTRIES (16),
    .CNT_BITS  (32)
  ) dut (
    .nclk                 (nclk),
    .nresetn              (nresetn),
    .s_axis_rx_tdata      (s_tdata),
    .s_axis_rx_tkeep      (s_tkeep),
    .s_axis_rx_tlast      (s_tlast),
    .s_axis_rx_tvalid     (s_tvalid),
    .s_axis_rx_tready     (s_tready),
    .m_axis_rx_tdata      (m_tdata),
    .m_axis_rx_tkeep      (m_tkeep),
    .m_axis_rx_tlast      (m_tlast),
    .m_axis_rx_tvalid     (m_tvalid),
    .m_axis_rx_tready     (m_tready),
    .acceptable_traffic_i (acceptable_traffic_i),
    .qpn_traffic_i        (qpn_traffic_i),
    .flush_i              (flush_i),
    .drop_count_o         (drop_count_o),
    .blocked_entries_o    (blocked_entries_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src_q[$];
  beat_t exp_q[$];

  // one-shot controls applied on the next cycle
  logic        sh_rst_n = 1'b1;
  logic        sh_ok    = 1'b1;
  logic [23:0] sh_qpn   = '0;
  logic        sh_flush = 1'b0;

  int ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 never
  bit rand_gap   = 0;
  bit tog        = 0;
  bit held       = 0;

  // reference state
  bit              bl_valid[N];
  logic [23:0]     bl_qpn[N];
  int              bl_victim = 0;
  bit              in_pkt = 0;
  bit              pkt_drop = 0;
  longint unsigned ref_drops = 0;
  int              out_cnt = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_present(input logic [23:0] q);
    for (int i = 0; i < N; i++) if (bl_valid[i] && bl_qpn[i] == q) return 1;
    return 0;
  endfunction

  function automatic int ref_occupancy();
    int c = 0;
    for (int i = 0; i < N; i++) if (bl_valid[i]) c++;
    return c;
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i < N; i++) bl_valid[i] = 0;
    bl_victim = 0;
    in_pkt    = 0;
    pkt_drop  = 0;
    ref_drops = 0;
    exp_q.delete();
  endfunction

  function automatic void ref_verdict(input logic ok, input logic [23:0] q, input logic fl);
    int slot = -1;
    if (fl) begin
      for (int i = 0; i < N; i++) bl_valid[i] = 0;
      bl_victim = 0;
      return;
    end
    if (q == 0) return;
    if (!ok && !ref_present(q)) begin
      for (int i = N - 1; i >= 0; i--) if (!bl_valid[i]) slot = i;
      if (slot >= 0) begin
        bl_valid[slot] = 1;
        bl_qpn[slot]   = q;
      end else begin
        bl_qpn[bl_victim] = q;
        bl_victim = (bl_victim + 1) % N;
      end
    end else if (ok) begin
      for (int i = 0; i < N; i++) if (bl_valid[i] && bl_qpn[i] == q) bl_valid[i] = 0;
    end
  endfunction

  function automatic void ref_beat(input beat_t b);
    logic [7:0]  op;
    logic [23:0] q;
    if (!in_pkt) begin
      op = b.data[231:224];
      q  = b.data[287:264];
      pkt_drop = (op == 8'h06 || op == 8'h07 || op == 8'h08 || op == 8'h0A) && ref_present(q);
      if (pkt_drop && ref_drops < 64'hFFFF_FFFF) ref_drops++;
    end
    in_pkt = !b.last;
    if (!pkt_drop) exp_q.push_back(b);
  endfunction

  task automatic push_pkt(input logic [7:0] op, input logic [23:0] q, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom();
      if (i == 0) begin
        b.data[231:224] = op;
        b.data[287:264] = q;
      end
      b.last = (i == n - 1);
      b.keep = b.last ? (64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 63)) : '1;
      src_q.push_back(b);
    end
  endtask

  task automatic cycle();
    logic  acc;
    logic  fire;
    beat_t b;
    @(negedge nclk);
    nresetn              = sh_rst_n;
    acceptable_traffic_i = sh_ok;
    qpn_traffic_i        = sh_qpn;
    flush_i              = sh_flush;
    sh_rst_n = 1'b1;
    sh_ok    = 1'b1;
    sh_qpn   = '0;
    sh_flush = 1'b0;
    if (held) s_tvalid = 1'b1;
    else s_tvalid = (src_q.size() != 0) && (!rand_gap || $urandom_range(0, 3) != 0);
    if (s_tvalid) begin
      s_tdata = src_q[0].data;
      s_tkeep = src_q[0].keep;
      s_tlast = src_q[0].last;
    end
    case (ready_mode)
      0: m_tready = 1'b1;
      1: begin tog = !tog; m_tready = tog; end
      2: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    #1;
    check("s_tready", 512'(s_tready), 512'(nresetn && (exp_q.size() == 0 || m_tready)));
    check("m_tvalid", 512'(m_tvalid), 512'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("m_tdata", m_tdata, exp_q[0].data);
      check("m_tkeep", 512'(m_tkeep), 512'(exp_q[0].keep));
      check("m_tlast", 512'(m_tlast), 512'(exp_q[0].last));
    end
    check("drop_count", 512'(drop_count_o), 512'(ref_drops));
    check("blocked_entries", 512'(blocked_entries_o), 512'(ref_occupancy()));
    acc  = s_tvalid && s_tready;
    fire = m_tvalid && m_tready;
    if (fire && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      out_cnt++;
    end
    if (!nresetn) begin
      ref_reset();
      src_q.delete();
      held = 0;
    end else begin
      if (acc) begin
        b = src_q.pop_front();
        ref_beat(b);
      end
      held = s_tvalid && !acc;
      ref_verdict(acceptable_traffic_i, qpn_traffic_i, flush_i);
    end
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cycles);
    check({tag, "_idle"}, 512'(src_q.size() + exp_q.size()), 512'(0));
    cycle();
    cycle();
  endtask

  logic [7:0] ops[10] = '{8'h06, 8'h07, 8'h08, 8'h0A, 8'h04, 8'h0C, 8'h10, 8'h11, 8'h00, 8'h0D};

  initial begin
    int base_out;
    longint unsigned base_drops;
    int r;
    int n;

    ref_reset();
    nresetn = 1'b0;
    repeat (2) @(posedge nclk);
    #1;
    check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check("rst_s_tready", 512'(s_tready), 512'(0));
    check("rst_drop_count", 512'(drop_count_o), 512'(0));
    check("rst_blocked", 512'(blocked_entries_o), 512'(0));
    sh_rst_n = 1'b0;
    cycle();
    cycle();

    // blocked write packet is dropped entirely
    base_out = out_cnt;
    sh_ok = 1'b0; sh_qpn = 24'h000123;
    cycle();
    push_pkt(8'h06, 24'h000123, 3);
    run_until_idle("blocked_write", 200);
    check("blocked_write_out", 512'(out_cnt - base_out), 512'(0));
    check("blocked_write_drops", 512'(drop_count_o), 512'(1));
    check("blocked_write_entries", 512'(blocked_entries_o), 512'(1));

    // unblocked QPN under toggling backpressure
    base_out = out_cnt;
    ready_mode = 1;
    push_pkt(8'h06, 24'h000124, 3);
    run_until_idle("backpressure", 200);
    check("backpressure_out", 512'(out_cnt - base_out), 512'(3));
    ready_mode = 0;

    // block then unblock
    base_out = out_cnt;
    sh_ok = 1'b0; sh_qpn = 24'h000123;
    cycle();
    sh_ok = 1'b1; sh_qpn = 24'h000123;
    cycle();
    push_pkt(8'h0A, 24'h000123, 1);
    run_until_idle("unblock", 200);
    check("unblock_out", 512'(out_cnt - base_out), 512'(1));
    check("unblock_entries", 512'(blocked_entries_o), 512'(0));

    // overflow replaces the oldest entry
    for (int q = 1; q <= 17; q++) begin
      sh_ok = 1'b0; sh_qpn = 24'(q);
      cycle();
    end
    cycle();
    check("overflow_entries", 512'(blocked_entries_o), 512'(16));
    base_out = out_cnt;
    base_drops = ref_drops;
    push_pkt(8'h0A, 24'd1, 1);
    push_pkt(8'h0A, 24'd2, 1);
    push_pkt(8'h0A, 24'd17, 1);
    run_until_idle("overflow", 200);
    check("overflow_out", 512'(out_cnt - base_out), 512'(1));
    check("overflow_drops", 512'(drop_count_o), 512'(base_drops + 2));

    // flush wins over a simultaneous blocking verdict
    sh_flush = 1'b1; sh_ok = 1'b0; sh_qpn = 24'h000077;
    cycle();
    cycle();
    check("flush_entries", 512'(blocked_entries_o), 512'(0));

    // verdict in the same cycle as the header beat applies to the next packet
    base_out = out_cnt;
    base_drops = ref_drops;
    push_pkt(8'h0A, 24'h000055, 1);
    sh_ok = 1'b0; sh_qpn = 24'h000055;
    cycle();
    push_pkt(8'h0A, 24'h000055, 1);
    run_until_idle("same_cycle", 200);
    check("same_cycle_out", 512'(out_cnt - base_out), 512'(1));
    check("same_cycle_drops", 512'(drop_count_o), 512'(base_drops + 1));

    // reset in the middle of a forwarded packet
    ready_mode = 3;
    push_pkt(8'h06, 24'h000200, 4);
    cycle();
    cycle();
    sh_rst_n = 1'b0;
    cycle();
    ready_mode = 0;
    base_out = out_cnt;
    push_pkt(8'h0C, 24'h000300, 1);
    run_until_idle("mid_reset", 200);
    check("mid_reset_out", 512'(out_cnt - base_out), 512'(1));
    check("mid_reset_drops", 512'(drop_count_o), 512'(0));
    check("mid_reset_entries", 512'(blocked_entries_o), 512'(0));

    // random traffic, verdicts and flushes
    rand_gap = 1;
    ready_mode = 2;
    for (int p = 0; p < 80; p++) begin
      push_pkt(ops[$urandom_range(0, 9)], 24'($urandom_range(0, 24)), int'($urandom_range(1, 4)));
    end
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        sh_ok = 1'b0; sh_qpn = 24'($urandom_range(0, 24));
      end else if (r < 55) begin
        sh_ok = 1'b1; sh_qpn = 24'($urandom_range(0, 24));
      end else if (r < 57) begin
        sh_flush = 1'b1; sh_ok = 1'b0; sh_qpn = 24'($urandom_range(1, 24));
      end
      cycle();
      n++;
    end
    check("random_idle", 512'(src_q.size() + exp_q.size()), 512'(0));
    ready_mode = 0;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
